udp_port_filter: RTL and testbench
==================================

Name: udp_port_filter

Overview:
- Downstream stage of mac_filter; consumes its AXI4-Stream output of Ethernet/IPv4 frames on 512-bit beats.
- Inspects the first beat of each packet and forwards only non-fragmented IPv4/UDP packets whose UDP destination port equals UDP_PORT. All other packets are discarded whole.
- Maintains saturating pass and drop counters for the dump flow.

Parameters:
- AXIS_DATA_WIDTH, 512, tdata width; fixed at 512, since header offsets assume a 64-byte first beat.
- AXIS_TUSER_WIDTH, 256, tuser width; passed through untouched.
- UDP_PORT, 16'd5353, UDP destination port to keep.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- axis_aclk  in  1  Clock.
- axis_reset  in  1  Synchronous reset, active-high.
- cnt_clear  in  1  Synchronous clear of both counters.
- s_axis_tdata  in  512  Input data; byte n at tdata[8n+7:8n].
- s_axis_tkeep  in  64  Input byte enables; bit n qualifies byte n.
- s_axis_tuser  in  256  Input sideband.
- s_axis_tvalid  in  1  Input valid.
- s_axis_tready  out  1  Input ready.
- s_axis_tlast  in  1  Input end of packet.
- m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast  out  512/64/256/1  Registered copy of a passed input beat.
- m_axis_tvalid  out  1  Output valid.
- m_axis_tready  in  1  Output ready.
- pass_cnt  out  CNT_WIDTH  Packets forwarded.
- drop_cnt  out  CNT_WIDTH  Packets discarded.

Behaviour:
- Reset: state=HEAD, all m_axis_* outputs=0, pass_cnt=0, drop_cnt=0.
- Reset overrides everything. A packet in flight at reset is abandoned. Its remaining beats arrive in HEAD and are parsed as a new header.
- Accept condition: a beat is accepted when s_axis_tvalid && s_axis_tready.

Output register (single stage):
- s_axis_tready = (state==DROP) || !m_axis_tvalid || m_axis_tready. This is combinational.
- A passed beat is loaded into the m_axis_* registers on accept. Latency is 1 cycle.
- m_axis_tvalid clears on m_axis_tready when no new beat loads. Load and drain in the same cycle sustain 1 beat/cycle.
- In HEAD, the tready term for a beat that will be dropped must still be the pipeline term, so header evaluation does not depend on tready.

Head check (combinational on the first beat; all fields big-endian across bytes):
- ver = byte14[7:4] must equal 4.
- ihl = byte14[3:0] must satisfy 5 ≤ ihl ≤ 11. The upper bound keeps the destination port inside the first beat.
- Fragment: ({byte20,byte21} & 16'h3FFF) must equal 0, i.e. MF=0 and offset=0.
- Protocol: byte23 must equal 8'd17.
- Port: dport = {byte[36+4*(ihl-5)], byte[37+4*(ihl-5)]} must equal UDP_PORT.
- Runt: tkeep[37+4*(ihl-5)] must be 1. Otherwise the packet is dropped.
- match = all of the above are true.

FSM:
- HEAD, on accept with match: forward the beat. If !tlast go to PASS, else stay in HEAD.
- HEAD, on accept without match: discard the beat. If !tlast go to DROP, else stay in HEAD.
- PASS: forward every accepted beat. On an accepted tlast beat, go to HEAD.
- DROP: discard every accepted beat; tready=1. On an accepted tlast beat, go to HEAD.

Counters:
- pass_cnt increments on the accept of a matching head beat.
- drop_cnt increments on the accept of a non-matching head beat.
- Both saturate at all-ones.
- cnt_clear forces both to 0 and takes priority over a coincident increment.

Other rules:
- tuser and tkeep are forwarded unmodified.
- Packet boundaries are preserved, and the output never carries partial packets.
- Consecutive single-beat packets are each evaluated independently.

Test Plan:
- UDP dport 5353 (0x14E9), ihl=5, 2-beat packet, m_axis_tready=1 → both beats appear on the master port 1 cycle after acceptance, tlast on beat 2, pass_cnt=1, drop_cnt=0.
- Same packet with dport 53 → no m_axis_tvalid, s_axis_tready=1 throughout, drop_cnt=1, FSM returns to HEAD after tlast.
- Header variants, each as a separate packet:
  - ihl=7 with dport 5353 at bytes 44-45 → passed.
  - ihl=12 → dropped.
  - protocol 6 → dropped.
  - MF=1 → dropped.
  - Result: pass_cnt=1, drop_cnt=3.
- Backpressure: m_axis_tready toggling 1010… over a 4-beat passing packet → no beat lost or duplicated; s_axis_tready low exactly when the output register is full and m_axis_tready=0.
- Back-to-back single-beat packets alternating pass/drop for 8 cycles → 4 forwarded, pass_cnt=4, drop_cnt=4, no bubble on accepts.
- Mid-packet events:
  - axis_reset asserted during beat 2 of a passing packet → outputs=0 and counters=0 next cycle.
  - cnt_clear asserted together with a head accept → counter reads 0.

Source files
------------

// File: rtl/udp_port_filter.sv
// Forwards non-fragmented IPv4/UDP packets whose destination port matches UDP_PORT,
// discards all other packets whole, and keeps saturating pass/drop packet counters.
module udp_port_filter #(
    parameter int          AXIS_DATA_WIDTH  = 512,
    parameter int          AXIS_TUSER_WIDTH = 256,
    parameter logic [15:0] UDP_PORT         = 16'd5353,
    parameter int          CNT_WIDTH        = 32
) (
    input  logic                            axis_aclk,
    input  logic                            axis_reset,
    input  logic                            cnt_clear,
    input  logic [AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [CNT_WIDTH-1:0]            pass_cnt,
    output logic [CNT_WIDTH-1:0]            drop_cnt
);

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [AXIS_DATA_WIDTH-1:0]   m_tdata_q,  m_tdata_d;
    logic [AXIS_DATA_WIDTH/8-1:0] m_tkeep_q,  m_tkeep_d;
    logic [AXIS_TUSER_WIDTH-1:0]  m_tuser_q,  m_tuser_d;
    logic                         m_tlast_q,  m_tlast_d;
    logic                         m_tvalid_q, m_tvalid_d;
    logic [CNT_WIDTH-1:0]         pass_cnt_q, pass_cnt_d;
    logic [CNT_WIDTH-1:0]         drop_cnt_q, drop_cnt_d;

    logic        accept;
    logic        forward;
    logic        head_accept;
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [15:0] frag_word;
    logic [7:0]  protocol;
    logic [5:0]  dport_hi_idx;
    logic [5:0]  dport_lo_idx;
    logic [15:0] dport;
    logic        match;

    assign ver       = s_axis_tdata[8*14+4 +: 4];
    assign ihl       = s_axis_tdata[8*14   +: 4];
    assign frag_word = {s_axis_tdata[8*20 +: 8], s_axis_tdata[8*21 +: 8]};
    assign protocol  = s_axis_tdata[8*23 +: 8];

    // IP options shift the UDP header by 4 bytes per extra ihl word; for ihl<=11 the
    // port stays inside the 64-byte first beat, other ihl values are rejected anyway.
    assign dport_hi_idx = 6'd36 + {ihl - 4'd5, 2'b00};
    assign dport_lo_idx = dport_hi_idx + 6'd1;
    assign dport        = {s_axis_tdata[{dport_hi_idx, 3'b000} +: 8],
                           s_axis_tdata[{dport_lo_idx, 3'b000} +: 8]};

    always_comb begin
        match = (ver == 4'd4)
             && (ihl >= 4'd5) && (ihl <= 4'd11)
             && ((frag_word & 16'h3FFF) == 16'h0000)
             && (protocol == 8'd17)
             && (dport == UDP_PORT)
             && s_axis_tkeep[dport_lo_idx];
    end

    assign s_axis_tready = (state_q == DROP) || !m_tvalid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d     = state_q;
        forward     = 1'b0;
        head_accept = 1'b0;
        case (state_q)
            HEAD: begin
                if (accept) begin
                    head_accept = 1'b1;
                    if (match) begin
                        forward = 1'b1;
                        if (!s_axis_tlast) state_d = PASS;
                    end else if (!s_axis_tlast) begin
                        state_d = DROP;
                    end
                end
            end
            PASS: begin
                if (accept) begin
                    forward = 1'b1;
                    if (s_axis_tlast) state_d = HEAD;
                end
            end
            DROP: begin
                if (accept && s_axis_tlast) state_d = HEAD;
            end
            default: state_d = HEAD;
        endcase
    end

    // A new beat may load while the previous one drains, sustaining one beat per cycle.
    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tuser_d  = m_tuser_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        if (forward) begin
            m_tdata_d  = s_axis_tdata;
            m_tkeep_d  = s_axis_tkeep;
            m_tuser_d  = s_axis_tuser;
            m_tlast_d  = s_axis_tlast;
            m_tvalid_d = 1'b1;
        end else if (m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (cnt_clear) begin
            pass_cnt_d = '0;
            drop_cnt_d = '0;
        end else if (head_accept) begin
            if (match && !(&pass_cnt_q)) pass_cnt_d = pass_cnt_q + 1'b1;
            if (!match && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q    <= HEAD;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tuser_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tuser_q  <= m_tuser_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign pass_cnt      = pass_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_udp_port_filter.sv
// Bench for udp_port_filter: header vectors from a table, scoreboard of forwarded beats,
// plus hand-written backpressure, back-to-back, mid-packet reset and counter-clear sequences.
module tb_udp_port_filter;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int UW = 256;
    localparam int CW = 32;

    logic          axis_aclk = 1'b0;
    logic          axis_reset;
    logic          cnt_clear;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] drop_cnt;

    always #5 axis_aclk = ~axis_aclk;

    udp_port_filter #(
        .AXIS_DATA_WIDTH (DW),
        .AXIS_TUSER_WIDTH(UW),
        .UDP_PORT        (16'd5353),
        .CNT_WIDTH       (CW)
    ) dut (
        .axis_aclk    (axis_aclk),
        .axis_reset   (axis_reset),
        .cnt_clear    (cnt_clear),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .pass_cnt     (pass_cnt),
        .drop_cnt     (drop_cnt)
    );

    typedef struct {
        logic [3:0]  ver;
        logic [3:0]  ihl;
        logic [15:0] frag;
        logic [7:0]  proto;
        logic [15:0] dport;
        bit          runt;
        int          nbeats;
        bit          exp_pass;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        int            acc_cyc;
        bit            chk_lat;
    } beat_t;

    vec_t  vecs[13];
    beat_t sb[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    int    cyc      = 0;
    bit    bp_mode  = 1'b0;
    int    exp_pass = 0;
    int    exp_drop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sampled at the falling edge: pops and compares any beat the sink is taking.
    task automatic checkOutput();
        beat_t e;
        if (bp_mode)
            check("bp_s_tready", 64'(s_axis_tready), 64'(!m_axis_tvalid || m_axis_tready));
        if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL unexpected_beat actual tvalid=1 tlast=%b required no beat", m_axis_tlast);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if ({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} !== {e.data, e.keep, e.user, e.last}) begin
                    n_fails++;
                    $display("[TB] FAIL out_beat actual last=%b keep=%h data=%h user=%h required last=%b keep=%h data=%h user=%h",
                             m_axis_tlast, m_axis_tkeep, m_axis_tdata[127:0], m_axis_tuser[127:0],
                             e.last, e.keep, e.data[127:0], e.user[127:0]);
                end
                if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'(1));
            end
        end
    endtask

    task automatic nextCycle();
        @(posedge axis_aclk);
        cyc++;
        #1;
        if (bp_mode) m_axis_tready = ~m_axis_tready;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] data, input logic [KW-1:0] keep,
                                 input logic [UW-1:0] user, input logic last,
                                 input bit fwd, output int waits);
        bit acc;
        s_axis_tdata  = data;
        s_axis_tkeep  = keep;
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        waits = 0;
        while (1) begin
            @(negedge axis_aclk);
            checkOutput();
            waits++;
            acc = s_axis_tready;
            if (acc && fwd)
                sb.push_back('{data, keep, user, last, cyc, !bp_mode && m_axis_tready});
            nextCycle();
            if (acc) break;
            if (waits >= 100) begin
                check("accept_timeout", 64'(0), 64'(1));
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) begin
            @(negedge axis_aclk);
            checkOutput();
            nextCycle();
        end
    endtask

    function automatic logic [UW-1:0] randUser();
        logic [UW-1:0] u;
        for (int i = 0; i < UW / 32; i++) u[32*i +: 32] = $urandom;
        return u;
    endfunction

    function automatic logic [DW-1:0] randData();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic void buildHead(input vec_t v, output logic [DW-1:0] data, output logic [KW-1:0] keep);
        int off;
        data = randData();
        keep = '1;
        data[8*12 +: 8] = 8'h08;
        data[8*13 +: 8] = 8'h00;
        data[8*14 +: 8] = {v.ver, v.ihl};
        data[8*20 +: 8] = v.frag[15:8];
        data[8*21 +: 8] = v.frag[7:0];
        data[8*23 +: 8] = v.proto;
        off = 36;
        if (v.ihl >= 4'd5 && v.ihl <= 4'd11) off = 36 + 4 * (int'(v.ihl) - 5);
        data[8*off +: 8]     = v.dport[15:8];
        data[8*(off+1) +: 8] = v.dport[7:0];
        if (v.runt)
            for (int j = off + 1; j < KW; j++) keep[j] = 1'b0;
    endfunction

    task automatic sendPacket(input vec_t v, input string name);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        int w;
        buildHead(v, d, k);
        applyStimulus(d, k, randUser(), v.nbeats == 1, v.exp_pass, w);
        for (int b = 1; b < v.nbeats; b++) begin
            applyStimulus(randData(), '1, randUser(), b == v.nbeats - 1, v.exp_pass, w);
            if (!v.exp_pass) check({name, "_drop_tready"}, 64'(w), 64'(1));
        end
        if (v.exp_pass) exp_pass++;
        else exp_drop++;
        idle(2);
        check({name, "_pass_cnt"}, 64'(pass_cnt), 64'(exp_pass));
        check({name, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        check("sb_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        vec_t v;
        int w;

        vecs[0]  = '{4'd4, 4'd5,  16'h0000, 8'd17, 16'd5353, 1'b0, 2, 1'b1};
        vecs[1]  = '{4'd4, 4'd5,  16'h0000, 8'd17, 16'd53,   1'b0, 2, 1'b0};
        vecs[2]  = '{4'd4, 4'd7,  16'h0000, 8'd17, 16'd5353, 1'b0, 2, 1'b1};
        vecs[3]  = '{4'd4, 4'd12, 16'h0000, 8'd17, 16'd5353, 1'b0, 2, 1'b0};
        vecs[4]  = '{4'd4, 4'd5,  16'h0000, 8'd6,  16'd5353, 1'b0, 2, 1'b0};
        vecs[5]  = '{4'd4, 4'd5,  16'h2000, 8'd17, 16'd5353, 1'b0, 2, 1'b0};
        vecs[6]  = '{4'd4, 4'd5,  16'h4000, 8'd17, 16'd5353, 1'b0, 1, 1'b1};
        vecs[7]  = '{4'd4, 4'd5,  16'h0001, 8'd17, 16'd5353, 1'b0, 1, 1'b0};
        vecs[8]  = '{4'd6, 4'd5,  16'h0000, 8'd17, 16'd5353, 1'b0, 1, 1'b0};
        vecs[9]  = '{4'd4, 4'd4,  16'h0000, 8'd17, 16'd5353, 1'b0, 1, 1'b0};
        vecs[10] = '{4'd4, 4'd11, 16'h0000, 8'd17, 16'd5353, 1'b0, 3, 1'b1};
        vecs[11] = '{4'd4, 4'd5,  16'h0000, 8'd17, 16'd5353, 1'b1, 1, 1'b0};
        vecs[12] = '{4'd4, 4'd11, 16'h0000, 8'd17, 16'd5353, 1'b1, 1, 1'b0};

        axis_reset    = 1'b1;
        cnt_clear     = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge axis_aclk);
        #1;
        axis_reset = 1'b0;
        @(negedge axis_aclk);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_m_tdata", 64'(|m_axis_tdata), 64'(0));
        check("rst_pass_cnt", 64'(pass_cnt), 64'(0));
        check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        check("rst_s_tready", 64'(s_axis_tready), 64'(1));
        nextCycle();

        $display("[TB] header vector table");
        for (int i = 0; i < 13; i++) sendPacket(vecs[i], $sformatf("vec%0d", i));
        drain();

        $display("[TB] backpressure on a 4-beat passing packet");
        v = vecs[0];
        v.nbeats = 4;
        bp_mode = 1'b1;
        sendPacket(v, "bp");
        drain();
        bp_mode = 1'b0;
        m_axis_tready = 1'b1;
        idle(1);

        $display("[TB] back-to-back single-beat packets");
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? vecs[6] : vecs[7];
            buildHead(v, d, k);
            applyStimulus(d, k, randUser(), 1'b1, v.exp_pass, w);
            check($sformatf("b2b%0d_no_bubble", i), 64'(w), 64'(1));
        end
        exp_pass += 4;
        exp_drop += 4;
        idle(2);
        check("b2b_pass_cnt", 64'(pass_cnt), 64'(exp_pass));
        check("b2b_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        drain();

        $display("[TB] reset during beat 2 of a passing packet");
        buildHead(vecs[0], d, k);
        applyStimulus(d, k, randUser(), 1'b0, 1'b1, w);
        s_axis_tdata  = randData();
        s_axis_tkeep  = '1;
        s_axis_tuser  = randUser();
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        axis_reset    = 1'b1;
        @(negedge axis_aclk);
        checkOutput();
        nextCycle();
        axis_reset    = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge axis_aclk);
        check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("midrst_m_tdata", 64'(|m_axis_tdata), 64'(0));
        check("midrst_m_tkeep", 64'(m_axis_tkeep), 64'(0));
        check("midrst_m_tuser", 64'(|m_axis_tuser), 64'(0));
        check("midrst_m_tlast", 64'(m_axis_tlast), 64'(0));
        check("midrst_pass_cnt", 64'(pass_cnt), 64'(0));
        check("midrst_drop_cnt", 64'(drop_cnt), 64'(0));
        nextCycle();
        sb.delete();
        exp_pass = 0;
        exp_drop = 0;
        sendPacket(vecs[0], "postrst");
        drain();

        $display("[TB] counter clear coincident with a head accept");
        buildHead(vecs[6], d, k);
        cnt_clear = 1'b1;
        applyStimulus(d, k, randUser(), 1'b1, 1'b1, w);
        cnt_clear = 1'b0;
        exp_pass = 0;
        exp_drop = 0;
        idle(1);
        check("clr_pass_cnt", 64'(pass_cnt), 64'(0));
        check("clr_drop_cnt", 64'(drop_cnt), 64'(0));
        sendPacket(vecs[1], "postclr");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
